// File: rtl/pid_pwm_out.sv
`default_nettype none
// ============================================================================
//  Module   : pid_pwm_out
//  Purpose  : Captures per-channel signed PID power words and drives a
//             double-buffered sign-magnitude PWM (pwm + dir) per channel,
//             with a dead period on reversal and a per-channel watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module pid_pwm_out #(
    parameter int AW  = 1,
    parameter int OW  = 12,
    parameter int PSW = 0,
    parameter int WDT = 4
) (
    input  logic              clk_pid,
    input  logic              reset_n,
    input  logic              ce,
    input  logic [AW-1:0]     a,
    input  logic [OW-1:0]     m_k,
    output logic [2**AW-1:0]  pwm,
    output logic [2**AW-1:0]  dir,
    output logic [2**AW-1:0]  run
);
    localparam int AN  = 2**AW;
    localparam int CW  = OW - 1;
    localparam int WDW = (WDT > 0) ? $clog2(WDT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    logic          w_tick;
    logic          w_wrap;
    logic [CW-1:0] r_cnt;

    // The most negative word has no positive twin; it clamps to full scale.
    function automatic logic [CW-1:0] f_mag(input logic [OW-1:0] m);
        logic [OW-1:0] neg;
        neg = -m;
        if (!m[OW-1])
            return m[CW-1:0];
        else if (neg[OW-1])
            return {CW{1'b1}};
        else
            return neg[CW-1:0];
    endfunction

    generate
        if (PSW > 0) begin : g_presc
            logic [PSW-1:0] r_presc;
            always_ff @(posedge clk_pid or negedge reset_n) begin
                if (!reset_n)
                    r_presc <= '0;
                else
                    r_presc <= r_presc + PSW'(1);
            end
            assign w_tick = &r_presc;
        end else begin : g_no_presc
            assign w_tick = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk_pid or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (w_tick)
            r_cnt <= r_cnt + CW'(1);
    end

    assign w_wrap = w_tick & (&r_cnt);

    generate
        for (genvar gi = 0; gi < AN; gi++) begin : g_ch
            state_t         r_state;
            state_t         w_state_nxt;
            logic [OW-1:0]  r_shadow;
            logic           r_fresh;
            logic [CW-1:0]  r_active;
            logic [CW-1:0]  w_active_nxt;
            logic [CW-1:0]  w_mag;
            logic           r_dir;
            logic           w_dir_nxt;
            logic           w_sgn;
            logic           w_wd_trip;
            logic [WDW-1:0] r_wd;
            logic [WDW-1:0] w_wd_nxt;
            logic           r_pwm;
            logic           r_run;

            assign w_mag     = f_mag(r_shadow);
            assign w_sgn     = r_shadow[OW-1];
            assign w_wd_trip = (WDT != 0) && (int'(r_wd) + 1 == WDT);

            always_comb begin
                w_state_nxt  = r_state;
                w_active_nxt = r_active;
                w_dir_nxt    = r_dir;
                w_wd_nxt     = r_wd;
                if (w_wrap) begin
                    if (r_fresh)
                        w_wd_nxt = '0;
                    else if (int'(r_wd) < WDT)
                        w_wd_nxt = r_wd + WDW'(1);

                    case (r_state)
                        S_GAP: begin
                            w_dir_nxt    = w_sgn;
                            w_active_nxt = w_mag;
                            w_state_nxt  = S_RUN;
                        end
                        S_IDLE, S_RUN: begin
                            if (!r_fresh && (r_state == S_IDLE || w_wd_trip)) begin
                                w_state_nxt  = S_IDLE;
                                w_active_nxt = '0;
                            end else if (w_sgn == r_dir || w_mag == '0) begin
                                w_state_nxt  = S_RUN;
                                w_active_nxt = w_mag;
                            end else begin
                                w_state_nxt  = S_GAP;
                                w_active_nxt = '0;
                            end
                        end
                        default: begin
                            w_state_nxt  = S_IDLE;
                            w_active_nxt = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk_pid or negedge reset_n) begin
                if (!reset_n) begin
                    r_state  <= S_IDLE;
                    r_shadow <= '0;
                    r_fresh  <= 1'b0;
                    r_active <= '0;
                    r_dir    <= 1'b0;
                    r_wd     <= '0;
                    r_pwm    <= 1'b0;
                    r_run    <= 1'b0;
                end else begin
                    r_state  <= w_state_nxt;
                    r_active <= w_active_nxt;
                    r_dir    <= w_dir_nxt;
                    r_wd     <= w_wd_nxt;
                    r_pwm    <= (r_state == S_RUN) && (r_cnt < r_active);
                    r_run    <= (r_state == S_RUN);
                    // A capture on the wrap cycle keeps fresh set for the next period.
                    if (ce && a == AW'(gi)) begin
                        r_shadow <= m_k;
                        r_fresh  <= 1'b1;
                    end else if (w_wrap) begin
                        r_fresh  <= 1'b0;
                    end
                end
            end

            assign pwm[gi] = r_pwm;
            assign dir[gi] = r_dir;
            assign run[gi] = r_run;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pid_pwm_out.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pid_pwm_out
//  Purpose  : Self-checking bench for pid_pwm_out (aw=1, ow=12, psw=0, wdt=4)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pid_pwm_out;
    localparam int AW   = 1;
    localparam int OW   = 12;
    localparam int PSW  = 0;
    localparam int WDT  = 4;
    localparam int AN   = 2;
    localparam int PER  = 2048;
    localparam int MAXD = 2047;

    logic          clk_pid = 1'b0;
    logic          reset_n = 1'b1;
    logic          ce      = 1'b0;
    logic [AW-1:0] a       = '0;
    logic [OW-1:0] m_k     = '0;
    logic [AN-1:0] pwm;
    logic [AN-1:0] dir;
    logic [AN-1:0] run;

    always #5 clk_pid = ~clk_pid;

    pid_pwm_out #(.AW(AW), .OW(OW), .PSW(PSW), .WDT(WDT)) dut (
        .clk_pid (clk_pid),
        .reset_n (reset_n),
        .ce      (ce),
        .a       (a),
        .m_k     (m_k),
        .pwm     (pwm),
        .dir     (dir),
        .run     (run)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one entry per channel, advanced once per PWM period.
    int md_state [AN];   // 0 idle, 1 run, 2 dead period
    int md_dir   [AN];
    int md_duty  [AN];
    int md_shadow[AN];
    int md_fresh [AN];
    int md_wd    [AN];

    typedef struct {
        int cyc;
        int ch;
        int val;
    } ev_t;
    ev_t sched[$];

    int            hi[AN];
    logic [AN-1:0] mid_dir;
    logic [AN-1:0] mid_run;

    function automatic int mag_of(input int v);
        int r;
        r = (v < 0) ? -v : v;
        return (r > MAXD) ? MAXD : r;
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < AN; ch++) begin
            md_state[ch] = 0; md_dir[ch] = 0; md_duty[ch] = 0;
            md_shadow[ch] = 0; md_fresh[ch] = 0; md_wd[ch] = 0;
        end
    endtask

    task automatic model_wrap();
        for (int ch = 0; ch < AN; ch++) begin
            int mg, sg, fr;
            mg = mag_of(md_shadow[ch]);
            sg = (md_shadow[ch] < 0) ? 1 : 0;
            fr = md_fresh[ch];
            if (md_state[ch] == 2) begin
                md_dir[ch] = sg; md_duty[ch] = mg; md_state[ch] = 1;
            end else if (fr == 0 && (md_state[ch] == 0 || md_wd[ch] + 1 == WDT)) begin
                md_state[ch] = 0; md_duty[ch] = 0;
            end else if (sg == md_dir[ch] || mg == 0) begin
                md_state[ch] = 1; md_duty[ch] = mg;
            end else begin
                md_state[ch] = 2; md_duty[ch] = 0;
            end
            md_wd[ch] = fr ? 0 : ((md_wd[ch] < WDT) ? md_wd[ch] + 1 : md_wd[ch]);
            md_fresh[ch] = 0;
        end
    endtask

    // One full PWM period; entered and left just after a falling clock edge.
    task automatic run_period();
        for (int ch = 0; ch < AN; ch++) hi[ch] = 0;
        for (int i = 0; i < PER; i++) begin
            ce = 1'b0;
            foreach (sched[k]) begin
                if (sched[k].cyc == i) begin
                    ce  = 1'b1;
                    a   = sched[k].ch[AW-1:0];
                    m_k = sched[k].val[OW-1:0];
                end
            end
            @(posedge clk_pid);
            #1;
            for (int ch = 0; ch < AN; ch++) hi[ch] += int'(pwm[ch]);
            if (i == PER / 2) begin
                mid_dir = dir;
                mid_run = run;
            end
            if (i == PER - 1) begin
                for (int ch = 0; ch < AN; ch++) begin
                    int exp_hi;
                    exp_hi = (md_state[ch] == 1) ? md_duty[ch] : 0;
                    checks++;
                    if (hi[ch] !== exp_hi) begin
                        errors++;
                        $display("FAIL period_high ch%0d: got %0d expected %0d", ch, hi[ch], exp_hi);
                    end
                    checks++;
                    if (mid_run[ch] !== (md_state[ch] == 1)) begin
                        errors++;
                        $display("FAIL period_run ch%0d: got %0b expected %0b", ch, mid_run[ch], md_state[ch] == 1);
                    end
                    checks++;
                    if (int'(mid_dir[ch]) !== md_dir[ch]) begin
                        errors++;
                        $display("FAIL period_dir ch%0d: got %0b expected %0d", ch, mid_dir[ch], md_dir[ch]);
                    end
                end
                model_wrap();
            end
            if (ce) begin
                md_shadow[int'(a)] = int'($signed(m_k));
                md_fresh[int'(a)]  = 1;
            end
            @(negedge clk_pid);
        end
        sched.delete();
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk_pid);
        checks++;
        if ({pwm, dir, run} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0", {pwm, dir, run});
        end
        reset_n = 1'b1;
        model_reset();
        run_period();
    endtask

    task automatic test_ce_on_wrap();
        sched.push_back('{PER - 1, 1, 100});
        run_period();
        run_period();
        checks++;
        if (hi[1] !== 0 || mid_run[1] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_ce_deferred: got high %0d run %0b expected 0 0", hi[1], mid_run[1]);
        end
        run_period();
        checks++;
        if (hi[1] !== 100 || mid_run[1] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_ce_applied: got high %0d run %0b expected 100 1", hi[1], mid_run[1]);
        end
    endtask

    task automatic test_forward();
        sched.push_back('{100, 0, 512});
        run_period();
        run_period();
        checks++;
        if (hi[0] !== 512 || mid_run[0] !== 1'b1 || mid_dir[0] !== 1'b0) begin
            errors++;
            $display("FAIL forward: got high %0d run %0b dir %0b expected 512 1 0", hi[0], mid_run[0], mid_dir[0]);
        end
    endtask

    task automatic test_reversal();
        sched.push_back('{50, 0, -300});
        run_period();
        run_period();
        checks++;
        if (hi[0] !== 0 || mid_dir[0] !== 1'b0) begin
            errors++;
            $display("FAIL reversal_gap: got high %0d dir %0b expected 0 0", hi[0], mid_dir[0]);
        end
        run_period();
        checks++;
        if (hi[0] !== 300 || mid_dir[0] !== 1'b1) begin
            errors++;
            $display("FAIL reversal_run: got high %0d dir %0b expected 300 1", hi[0], mid_dir[0]);
        end
    endtask

    task automatic test_clamp();
        sched.push_back('{200, 1, -2048});
        run_period();
        run_period();
        checks++;
        if (hi[1] !== 0) begin
            errors++;
            $display("FAIL clamp_gap: got high %0d expected 0", hi[1]);
        end
        run_period();
        checks++;
        if (hi[1] !== MAXD || mid_dir[1] !== 1'b1) begin
            errors++;
            $display("FAIL clamp_run: got high %0d dir %0b expected 2047 1", hi[1], mid_dir[1]);
        end
    endtask

    task automatic test_watchdog();
        sched.push_back('{300, 0, -700});
        run_period();
        for (int p = 1; p <= 5; p++) begin
            run_period();
            if (p == 4) begin
                checks++;
                if (hi[0] !== 700 || mid_run[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL watchdog_last_run: got high %0d run %0b expected 700 1", hi[0], mid_run[0]);
                end
            end
        end
        checks++;
        if (hi[0] !== 0 || mid_run[0] !== 1'b0 || mid_dir[0] !== 1'b1) begin
            errors++;
            $display("FAIL watchdog_idle: got high %0d run %0b dir %0b expected 0 0 1", hi[0], mid_run[0], mid_dir[0]);
        end
    endtask

    task automatic test_random();
        for (int p = 0; p < 10; p++) begin
            int n;
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                ev_t e;
                int  sel;
                e.cyc = ($urandom_range(0, 5) == 0) ? PER - 1 : $urandom_range(0, PER - 1);
                e.ch  = $urandom_range(0, AN - 1);
                sel   = $urandom_range(0, 5);
                case (sel)
                    0:       e.val = -2048;
                    1:       e.val = 0;
                    2:       e.val = 2047;
                    default: e.val = $urandom_range(0, 4095) - 2048;
                endcase
                sched.push_back(e);
            end
            run_period();
        end
    endtask

    task automatic test_async_reset();
        sched.push_back('{10, 0, -1500});
        run_period();
        sched.push_back('{10, 0, -1500});
        run_period();
        ce = 1'b0;
        for (int k = 0; k < 100; k++) @(posedge clk_pid);
        #1;
        checks++;
        if (pwm[0] !== 1'b1 || dir[0] !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: got pwm %0b dir %0b expected 1 1", pwm[0], dir[0]);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({pwm, dir, run} !== '0) begin
            errors++;
            $display("FAIL async_clear: got %b expected 0", {pwm, dir, run});
        end
        @(negedge clk_pid);
        @(negedge clk_pid);
        reset_n = 1'b1;
        model_reset();
        run_period();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ce_on_wrap();
        test_forward();
        test_reversal();
        test_clamp();
        test_watchdog();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
